// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Brief    : Shared types and constants for the gshare branch predictor:
//             counter-state enum, branch opcodes, F/D register layout and
//             the saturating 2-bit counter update.
//  Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Upper bound on the BHT index width carried in the F/D register; the
  // predictor instance uses the low IDX_W bits of the stored index.
  localparam int c_IDX_MAX_W = 16;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_cnt_e;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef struct packed {
    logic                   valid;
    logic                   taken;
    logic [c_IDX_MAX_W-1:0] idx;
    logic [31:0]            pc_plus4;
    logic [31:0]            target;
  } bp_fd_t;

  // Move the counter one step toward the resolved direction, pinned at the ends.
  function automatic bp_cnt_e bp_sat_update(input bp_cnt_e cnt, input logic taken);
    bp_cnt_e nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != STRONG_T) nxt = bp_cnt_e'(cnt + 2'd1);
    end else begin
      if (cnt != STRONG_NT) nxt = bp_cnt_e'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_table.sv
`default_nettype none
// ============================================================================
//  Module   : bht_table
//  Brief    : 2^IDX_W x 2-bit branch history table. One combinational read
//             port; one write port applying a saturating counter update.
//  Revision : 1.0 - initial release
// ============================================================================
module bht_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bp_cnt_e          o_rd_cnt,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int c_DEPTH = 2 ** IDX_W;

  bp_cnt_e r_bht [c_DEPTH];

  // Read is unbypassed: a same-cycle write is only visible after the edge.
  assign o_rd_cnt = r_bht[i_rd_idx];

  // Table storage: reset every entry to weakly-not-taken, update on resolve.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_bht[i] <= WEAK_NT;
      end
    end else if (i_we) begin
      r_bht[i_wr_idx] <= bp_sat_update(r_bht[i_wr_idx], i_wr_taken);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Brief    : gshare direction predictor for a 5-stage MIPS pipeline.
//             Predecodes beq/bne in Fetch, predicts from PC^GHR-indexed 2-bit
//             counters, carries the prediction to Decode and flags misses
//             with the recovery PC. Keeps branch/miss performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      pc_f_i,
  input  logic [31:0]      instr_f_i,
  input  logic             stall_f_i,
  input  logic             stall_d_i,
  input  logic             flush_d_i,
  input  logic [1:0]       branch_d_i,
  input  logic             pc_src_d_i,
  output logic             predict_taken_f_o,
  output logic [31:0]      predict_pc_f_o,
  output logic             predict_miss_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  logic [GHR_W-1:0] r_ghr;
  bp_fd_t           r_fd;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [5:0]       w_op_f;
  logic             w_is_br_f;
  logic [31:0]      w_pc_plus4_f;
  logic [31:0]      w_target_f;
  logic [IDX_W-1:0] w_ghr_ext;
  logic [IDX_W-1:0] w_idx_f;
  bp_cnt_e          w_rd_cnt;
  bp_fd_t           w_fd_f;
  logic [IDX_W-1:0] w_idx_d;
  logic             w_res_d;
  logic             w_miss_d;
  logic [GHR_W-1:0] w_ghr_next;
  logic             w_unused_bits;

  // ---------------- Fetch: predecode, target, index, prediction -----------
  assign w_op_f       = instr_f_i[31:26];
  assign w_is_br_f    = (w_op_f == OP_BEQ) || (w_op_f == OP_BNE);
  assign w_pc_plus4_f = pc_f_i + 32'd4;
  assign w_target_f   = w_pc_plus4_f + {{14{instr_f_i[15]}}, instr_f_i[15:0], 2'b00};
  assign w_ghr_ext    = IDX_W'(r_ghr);
  assign w_idx_f      = pc_f_i[IDX_W+1:2] ^ w_ghr_ext;

  assign predict_taken_f_o = w_is_br_f & w_rd_cnt[1];
  assign predict_pc_f_o    = predict_taken_f_o ? w_target_f : w_pc_plus4_f;

  assign w_fd_f.valid    = w_is_br_f;
  assign w_fd_f.taken    = predict_taken_f_o;
  assign w_fd_f.idx      = c_IDX_MAX_W'(w_idx_f);
  assign w_fd_f.pc_plus4 = w_pc_plus4_f;
  assign w_fd_f.target   = w_target_f;

  // ---------------- Decode: resolve and miss detection --------------------
  // Resolution is suppressed while Decode is stalled: operands may be stale.
  assign w_idx_d  = r_fd.idx[IDX_W-1:0];
  assign w_res_d  = r_fd.valid && (branch_d_i != 2'b00) && !stall_d_i;
  assign w_miss_d = w_res_d && (r_fd.taken != pc_src_d_i);

  assign predict_miss_o = w_miss_d;
  assign redirect_pc_o  = pc_src_d_i ? r_fd.target : r_fd.pc_plus4;
  assign branch_cnt_o   = r_branch_cnt;
  assign miss_cnt_o     = r_miss_cnt;

  // Global history shift; a 1-bit history simply records the last outcome.
  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign w_ghr_next = pc_src_d_i;
    end else begin : g_ghr_shift
      assign w_ghr_next = {r_ghr[GHR_W-2:0], pc_src_d_i};
    end
  endgenerate

  // Fetch has no state of its own, so its stall and the unused instruction
  // fields only need to be consumed here.
  assign w_unused_bits = ^{stall_f_i, instr_f_i[25:16], r_fd.idx, w_rd_cnt[0]};

  bht_table #(
    .IDX_W (IDX_W)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_rd_idx   (w_idx_f),
    .o_rd_cnt   (w_rd_cnt),
    .i_we       (w_res_d),
    .i_wr_idx   (w_idx_d),
    .i_wr_taken (pc_src_d_i)
  );

  // F/D pipeline register: stall holds (beats flush), flush drops valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fd <= '0;
    end else if (stall_d_i) begin
      r_fd <= r_fd;
    end else if (flush_d_i) begin
      r_fd.valid <= 1'b0;
    end else begin
      r_fd <= w_fd_f;
    end
  end

  // Global history register advances once per resolved branch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ghr <= '0;
    end else if (w_res_d) begin
      r_ghr <= w_ghr_next;
    end
  end

  // Saturating performance counters for resolved branches and misses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_res_d && (r_branch_cnt != {CNT_W{1'b1}})) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_miss_d && (r_miss_cnt != {CNT_W{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Brief    : Self-checking bench for branch_predictor with a reference model
//             and an expectation queue (GHR_W=1, CNT_W=4 build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int IDX_W = 6;
  localparam int GHR_W = 1;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      pc_f = 32'h0;
  logic [31:0]      instr_f = 32'h0;
  logic             stall_f = 1'b0;
  logic             stall_d = 1'b0;
  logic             flush_d = 1'b0;
  logic [1:0]       branch_d = 2'b00;
  logic             pc_src_d = 1'b0;
  logic             pt_o;
  logic [31:0]      ppc_o;
  logic             miss_o;
  logic [31:0]      redir_o;
  logic [CNT_W-1:0] bcnt_o;
  logic [CNT_W-1:0] mcnt_o;

  branch_predictor #(
    .IDX_W (IDX_W),
    .GHR_W (GHR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .pc_f_i            (pc_f),
    .instr_f_i         (instr_f),
    .stall_f_i         (stall_f),
    .stall_d_i         (stall_d),
    .flush_d_i         (flush_d),
    .branch_d_i        (branch_d),
    .pc_src_d_i        (pc_src_d),
    .predict_taken_f_o (pt_o),
    .predict_pc_f_o    (ppc_o),
    .predict_miss_o    (miss_o),
    .redirect_pc_o     (redir_o),
    .branch_cnt_o      (bcnt_o),
    .miss_cnt_o        (mcnt_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic             pt;
    logic [31:0]      ppc;
    logic             miss;
    logic [31:0]      redir;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0]       m_bht [2**IDX_W];
  logic [GHR_W-1:0] m_ghr;
  logic             m_valid;
  logic             m_taken;
  logic [IDX_W-1:0] m_idx;
  logic [31:0]      m_p4;
  logic [31:0]      m_tgt;
  logic [CNT_W-1:0] m_bc;
  logic [CNT_W-1:0] m_mc;

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_br(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2**IDX_W; i++) m_bht[i] = 2'b01;
    m_ghr   = '0;
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_idx   = '0;
    m_p4    = '0;
    m_tgt   = '0;
    m_bc    = '0;
    m_mc    = '0;
  endtask

  // Asynchronous reset, checking outputs while reset is asserted.
  task automatic do_reset();
    rst_n    = 1'b0;
    pc_f     = 32'h40;
    instr_f  = mk_br(6'b000100, 16'h0003);
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    branch_d = 2'b01;
    pc_src_d = 1'b1;
    model_reset();
    sb.delete();
    #2;
    check_eq("rst_pt",   32'(pt_o),   32'd0);
    check_eq("rst_ppc",  ppc_o,       32'h44);
    check_eq("rst_miss", 32'(miss_o), 32'd0);
    check_eq("rst_bcnt", 32'(bcnt_o), 32'd0);
    check_eq("rst_mcnt", 32'(mcnt_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One cycle: drive, push model expectation, compare at negedge, advance model.
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic sd,
                      input logic fd, input logic [1:0] bd, input logic src);
    exp_t e, o;
    logic isb, pt, res;
    logic [31:0] p4, tg;
    logic [IDX_W-1:0] ix;
    pc_f = pc; instr_f = ins; stall_d = sd; stall_f = sd; flush_d = fd;
    branch_d = bd; pc_src_d = src;
    isb = (ins[31:26] == 6'b000100) || (ins[31:26] == 6'b000101);
    p4  = pc + 32'd4;
    tg  = p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    ix  = pc[IDX_W+1:2] ^ IDX_W'(m_ghr);
    pt  = isb & m_bht[ix][1];
    res = m_valid && (bd != 2'b00) && !sd;
    e.pt    = pt;
    e.ppc   = pt ? tg : p4;
    e.miss  = res && (m_taken != src);
    e.redir = src ? m_tgt : m_p4;
    e.bc    = m_bc;
    e.mc    = m_mc;
    sb.push_back(e);
    @(negedge clk);
    check_eq("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      o = sb.pop_front();
      check_eq("pred_taken", 32'(pt_o),   32'(o.pt));
      check_eq("pred_pc",    ppc_o,       o.ppc);
      check_eq("miss",       32'(miss_o), 32'(o.miss));
      if (o.miss) check_eq("redirect", redir_o, o.redir);
      check_eq("branch_cnt", 32'(bcnt_o), 32'(o.bc));
      check_eq("miss_cnt",   32'(mcnt_o), 32'(o.mc));
    end
    if (res) begin
      if (src && m_bht[m_idx] != 2'b11) m_bht[m_idx] = m_bht[m_idx] + 2'd1;
      else if (!src && m_bht[m_idx] != 2'b00) m_bht[m_idx] = m_bht[m_idx] - 2'd1;
      m_ghr = GHR_W'({m_ghr, src});
      if (m_bc != '1) m_bc = m_bc + 1'b1;
      if (e.miss && m_mc != '1) m_mc = m_mc + 1'b1;
    end
    if (!sd) begin
      if (fd) m_valid = 1'b0;
      else begin
        m_valid = isb; m_taken = pt; m_idx = ix; m_p4 = p4; m_tgt = tg;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;

    // Reset, beq at 0x40 predicted not-taken, resolves taken -> miss to 0x50
    do_reset();
    step(32'h40, mk_br(6'b000100, 16'h0003), 0, 0, 2'b00, 0);
    step(32'h44, NOP, 0, 0, 2'b01, 1);
    check_eq("t1_mcnt_model", 32'(m_mc), 32'd1);
    step(32'h48, NOP, 0, 0, 2'b00, 0);

    // Loop branch taken four times (two warm-up misses), then back-to-back
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(32'h100, mk_br(6'b000100, 16'hFFFC), 0, 0, 2'b00, 0);
      step(32'hF4,  NOP, 0, 0, 2'b01, 1);
    end
    step(32'hF8, NOP, 0, 0, 2'b00, 0);
    check_eq("loop_bcnt", 32'(bcnt_o), 32'd4);
    check_eq("loop_mcnt", 32'(mcnt_o), 32'd2);
    step(32'h100, mk_br(6'b000100, 16'hFFFC), 0, 0, 2'b00, 0);
    step(32'h104, mk_br(6'b000101, 16'h0002), 0, 0, 2'b01, 1);
    step(32'h108, NOP, 0, 0, 2'b10, 0);
    step(32'h10C, NOP, 0, 0, 2'b00, 0);

    // Decode stall for three cycles with a mismatching outcome
    do_reset();
    step(32'h80, mk_br(6'b000100, 16'h0005), 0, 0, 2'b00, 0);
    for (int k = 0; k < 3; k++) step(32'h84, NOP, 1, 0, 2'b01, 1);
    step(32'h84, NOP, 0, 0, 2'b01, 1);
    step(32'h88, NOP, 0, 0, 2'b00, 0);
    check_eq("stall_bcnt", 32'(bcnt_o), 32'd1);
    check_eq("stall_mcnt", 32'(mcnt_o), 32'd1);

    // Flush with bne in Fetch: nothing resolves next cycle
    do_reset();
    step(32'hC0, mk_br(6'b000101, 16'h0004), 0, 1, 2'b00, 0);
    step(32'hC4, NOP, 0, 0, 2'b10, 1);
    step(32'hC8, NOP, 0, 0, 2'b00, 0);

    // Stall and flush together hold the F/D contents
    step(32'hD0, mk_br(6'b000100, 16'h0008), 0, 0, 2'b00, 0);
    step(32'hE0, mk_br(6'b000101, 16'h0001), 1, 1, 2'b01, 1);
    step(32'hE0, NOP, 0, 0, 2'b01, 1);
    step(32'hE4, NOP, 0, 0, 2'b00, 0);

    // In-flight branch discarded by reset
    step(32'h300, mk_br(6'b000100, 16'h0002), 0, 0, 2'b00, 0);
    do_reset();
    step(32'h304, NOP, 0, 0, 2'b01, 1);

    // Every resolution mispredicts: both counters pin at 4'hF
    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(32'h200 + 32'(8 * k), mk_br(6'b000100, 16'h0001), 0, 0, 2'b00, 0);
      step(32'h600, NOP, 0, 0, 2'b01, !m_taken);
    end
    step(32'h604, NOP, 0, 0, 2'b00, 0);
    check_eq("sat_mcnt", 32'(mcnt_o), 32'hF);
    check_eq("sat_bcnt", 32'(bcnt_o), 32'hF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic gshare branch predictor for the five-stage MIPS pipeline. It predecodes `beq`/`bne` in Fetch, predicts direction from a table of 2-bit saturating counters indexed by PC XOR global history, and supplies the predicted next PC. It carries the prediction into Decode, compares it against the branch outcome resolved there, and drives `predict_miss_o` plus the recovery PC. The hazard unit consumes `predict_miss_o` and returns `stall_f`, `stall_d` and `flush_d`.

## Interface
- `IDX_W`, 6: BHT index width; the table has 2^IDX_W entries.
- `GHR_W`, 6: global history length; must be ≤ IDX_W.
- `CNT_W`, 32: width of the performance counters.

Ports. One clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  async active-low reset
- `pc_f_i`  in  32  Fetch PC
- `instr_f_i`  in  32  Fetch instruction (combinational IMEM read)
- `stall_f_i`  in  1  Fetch stall from the hazard unit
- `stall_d_i`  in  1  Decode stall from the hazard unit
- `flush_d_i`  in  1  Decode flush from the hazard unit
- `branch_d_i`  in  2  Decode branch type; non-zero means conditional branch
- `pc_src_d_i`  in  1  resolved outcome in Decode (1 = taken)
- `predict_taken_f_o`  out  1  Fetch prediction
- `predict_pc_f_o`  out  32  predicted next PC
- `predict_miss_o`  out  1  misprediction in Decode
- `redirect_pc_o`  out  32  correct next PC when `predict_miss_o` is 1
- `branch_cnt_o`  out  CNT_W  resolved branches
- `miss_cnt_o`  out  CNT_W  mispredictions

## Operation
- **F predecode.** `is_br_f` = opcode 6'b000100 or 6'b000101.
- **F branch target.** `target_f` = pc_f+4 + (sext(imm16)<<2).
- **F index.** `idx_f` = pc_f[IDX_W+1:2] ^ {0, ghr}.
- **F prediction.**
  - `predict_taken_f_o` = `is_br_f` & `bht[idx_f][1]`.
  - `predict_pc_f_o` = `predict_taken_f_o` ? `target_f` : pc_f+4.
- **F/D register** holds `{valid, taken, idx, pc_plus4, target}`.
  - `stall_d_i` = 1: hold. This has priority over `flush_d_i`.
  - Otherwise, `flush_d_i` = 1: clear `valid`.
  - Otherwise: load `valid` = `is_br_f`, and load the other fields.
- **Resolve.** `res_d` = `valid_d` & (`branch_d_i` != 0) & !`stall_d_i`.
  - Outcome must not be sampled during a D stall, because operands may be stale.
- **Miss detection.**
  - `predict_miss_o` = `res_d` & (`taken_d` != `pc_src_d_i`).
  - `redirect_pc_o` = `pc_src_d_i` ? `target_d` : `pc_plus4_d`.
- **Update on `res_d`.**
  - `bht[idx_d]` increments if taken, decrements if not taken.
  - The counter saturates at 2'b11 and 2'b00.
  - `ghr` <= {ghr[GHR_W-2:0], pc_src_d_i}.
  - `branch_cnt_o` +1; `miss_cnt_o` +1 on a miss. Both saturate at all-ones.
- **Counter states:** STRONG_NT 00, WEAK_NT 01, WEAK_T 10, STRONG_T 11.

## Timing
- Prediction is combinational in F from registered state; it adds zero cycles.
- Miss is flagged in the same cycle the branch sits unstalled in D. The 1-cycle penalty is the flushed F/D slot.
- Table and GHR updates are visible from the next edge.
  - A same-cycle F lookup of the entry being updated sees the old value; there is no bypass.
  - The F index uses the old GHR in that cycle.
- **Reset values:**
  - All BHT entries WEAK_NT; `ghr` 0; `valid_d` 0; both counters 0.
  - Hence `predict_taken_f_o` 0, `predict_miss_o` 0, `predict_pc_f_o` = pc_f+4.
  - Reset mid-operation discards the in-flight prediction.
- `stall_f_i` needs no internal action, because F state is combinational. It is accepted for interface symmetry.
- **Branch stalled N cycles in D:** no miss and no update for N cycles; exactly one update when the stall drops.
- **Back-to-back branches:** each resolves independently. The second uses the GHR value from before the first update.

## Structure
- **Package `bp_pkg`:**
  - `bp_cnt_e` enum (the four counter states).
  - `OP_BEQ`, `OP_BNE` opcode constants.
  - `bp_fd_t` struct for the F/D register.
- **Sub-module `bht_table`:**
  - 2^IDX_W × 2-bit array.
  - Async-reset to WEAK_NT.
  - One combinational read port.
  - One write port that performs the saturating update.

## Test plan
- **Reset, then fetch `beq` at pc 0x40 with imm 0x0003** → `predict_taken_f_o` 0, `predict_pc_f_o` 0x44. Resolve taken in D → `predict_miss_o` 1, `redirect_pc_o` 0x50, `miss_cnt_o` 1.
- **Same loop branch taken 4 times, GHR_W=1 for the run** → first two resolutions miss, later ones hit. Counter at the active index reaches 11 and stays; `branch_cnt_o` 4, `miss_cnt_o` 2.
- **Branch in D with `stall_d_i` high for 3 cycles and mismatching `pc_src_d_i`** → `predict_miss_o` 0 throughout the stall. Exactly one update and one miss on the fourth cycle.
- **`flush_d_i` with a `bne` in F** → `valid_d` 0 next cycle; no update or miss even if `branch_d_i` is non-zero.
- **`stall_d_i` and `flush_d_i` together** → F/D contents held unchanged.
- **Force `miss_cnt_o` to all-ones via a CNT_W=4 build, then another miss** → stays 4'hF.
